// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO behind the UART receiver, with a first-word-fall-through read port,
// 16550-style line-status flags, and trigger-level/character-timeout interrupts.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_perr,
    input  logic              rx_ferr,
    input  logic              rx_serr,
    input  logic              rd_en,
    input  logic              lsr_rd,
    input  logic              fifo_clr,
    input  logic [1:0]        rx_trig,
    output logic [7:0]        rd_data,
    output logic              rd_perr,
    output logic              data_ready,
    output logic              fifo_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun_err,
    output logic              framing_err,
    output logic              start_err,
    output logic              fifo_perr,
    output logic              rx_int,
    output logic              timeout_int
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [8:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d, perr_cnt_q, perr_cnt_d, trig_lvl;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              done_q, ferr_q, serr_q;
    logic              overrun_q, overrun_d, framing_q, framing_d, start_q, start_d;
    logic              push_ev, pop, full, wr_en, ovr_set;
    logic [8:0]        head;

    always_comb begin
        head       = mem_q[rd_ptr_q];
        push_ev    = rx_done & ~done_q;
        pop        = rd_en & (count_q != '0);
        full       = count_q == (ADDR_W+1)'(DEPTH);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
        wr_en      = push_ev & ~fifo_clr & (~full | pop);
        ovr_set    = push_ev & ~fifo_clr & full & ~pop;
        wr_ptr_d   = fifo_clr ? '0 : wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d   = fifo_clr ? '0 : rd_ptr_q + ADDR_W'(pop);
        count_d    = fifo_clr ? '0 : count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
        perr_cnt_d = fifo_clr ? '0 : perr_cnt_q + (ADDR_W+1)'(wr_en & rx_perr)
                                   - (ADDR_W+1)'(pop & head[8]);
        tmo_d      = (push_ev | pop | fifo_clr | count_q == '0) ? '0 :
                     (tmo_q == TW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + TW'(1);
        overrun_d  = ovr_set | (overrun_q & ~lsr_rd);
        framing_d  = (rx_ferr & ~ferr_q) | (framing_q & ~lsr_rd);
        start_d    = (rx_serr & ~serr_q) | (start_q & ~lsr_rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            perr_cnt_q <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            serr_q     <= 1'b0;
            overrun_q  <= 1'b0;
            framing_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            perr_cnt_q <= perr_cnt_d;
            tmo_q      <= tmo_d;
            done_q     <= rx_done;
            ferr_q     <= rx_ferr;
            serr_q     <= rx_serr;
            overrun_q  <= overrun_d;
            framing_q  <= framing_d;
            start_q    <= start_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {rx_perr, rx_data};
    end

    always_comb begin
        trig_lvl    = rx_trig == 2'd0 ? (ADDR_W+1)'(1) :
                      rx_trig == 2'd1 ? (ADDR_W+1)'(4) :
                      rx_trig == 2'd2 ? (ADDR_W+1)'(8) : (ADDR_W+1)'(14);
        data_ready  = count_q != '0;
        rd_data     = data_ready ? head[7:0] : '0;
        rd_perr     = data_ready & head[8];
        fifo_full   = full;
        count       = count_q;
        overrun_err = overrun_q;
        framing_err = framing_q;
        start_err   = start_q;
        fifo_perr   = perr_cnt_q != '0;
        rx_int      = count_q >= trig_lvl;
        timeout_int = (tmo_q == TW'(TIMEOUT_CYC)) & data_ready;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer stage directly downstream of the UART receiver timing/shift-register block. It captures each completed character (out_rx plus its parity-error flag) on the receiver's completion indication and queues it in a DEPTH-entry FIFO. It presents a first-word-fall-through read port and 16550-style line-status flags to the host bus. It also raises a trigger-level interrupt and a character-timeout interrupt.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two.
ADDR_W, 4, log2(DEPTH).
TIMEOUT_CYC, 64, idle cycles with a non-empty FIFO before timeout_int asserts.

Ports:
clk  input  1  system clock (same baud/oversample clock as the receiver)
reset  input  1  asynchronous, active-low reset
rx_data  input  8  character from the receiver (its out_rx)
rx_done  input  1  receiver completion level (its done_rx); push on rising edge only
rx_perr  input  1  receiver parity_bit_error
rx_ferr  input  1  receiver framing_stop_error
rx_serr  input  1  receiver start_bit_error
rd_en  input  1  host pop strobe, one cycle per character
lsr_rd  input  1  host line-status read strobe; clears sticky flags
fifo_clr  input  1  synchronous flush
rx_trig  input  2  trigger level: 00=1, 01=4, 10=8, 11=14 entries
rd_data  output  8  head entry data (valid when data_ready=1)
rd_perr  output  1  parity-error flag of head entry
data_ready  output  1  FIFO not empty
fifo_full  output  1  count==DEPTH
count  output  ADDR_W+1  entries held
overrun_err  output  1  sticky: push attempted while full
framing_err  output  1  sticky: rising edge seen on rx_ferr
start_err  output  1  sticky: rising edge seen on rx_serr
fifo_perr  output  1  any stored entry has parity flag set
rx_int  output  1  count >= trigger level
timeout_int  output  1  character-timeout interrupt

Behaviour:
- Reset (reset=0, async): pointers, count, done/ferr/serr edge registers, timeout counter, all sticky flags = 0. All outputs therefore 0, including rd_data (memory is read as 0 when empty).
- Push event: rx_done & ~rx_done_q, where rx_done_q is a registered copy of rx_done. The receiver holds done_rx high while idle, so a level never causes more than one push.
- On push, write {rx_perr, rx_data} at wr_ptr. Captured values are those present in the edge cycle.
- Pop event: rd_en & data_ready. Pop advances rd_ptr. rd_en while empty is ignored: no pointer change, no error.
- rd_data/rd_perr are combinational from mem[rd_ptr] (first-word fall-through). A pushed entry is visible the cycle after the push edge; latency is 1 clk.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged when both occur.
- Full + push, no pop: entry discarded, FIFO contents unchanged, overrun_err <= 1.
- Full + push + pop same cycle: both performed, no overrun.
- Empty + push + pop same cycle: the pop is invalid (data_ready=0), so only the push occurs.
- Sticky flags (overrun_err, framing_err, start_err) are cleared by lsr_rd. If a set and lsr_rd coincide in the same cycle, the set wins.
- fifo_perr = OR of the parity bit over occupied entries. It is maintained as a counter of flagged entries: +1 on push with rx_perr, -1 on pop of a flagged head.
- fifo_clr: pointers, count, and the parity counter go to 0 next cycle. A push in the same cycle is dropped. Sticky flags are unaffected.
- rx_int = (count >= {1,4,8,14}[rx_trig]). This is combinational from registered count, and rx_trig may change at any time.
- Timeout counter, ceil(log2(TIMEOUT_CYC+1)) bits:
  - Cleared on push, pop, fifo_clr, or count==0.
  - Otherwise increments, saturating at TIMEOUT_CYC.
  - timeout_int = (counter==TIMEOUT_CYC) && count!=0.

Test Plan:
1. Reset then rx_data=8'hA5 with rx_done 0->1, held high 10 cycles -> exactly one push; next cycle data_ready=1, rd_data=A5, count=1; rd_en pulse -> data_ready=0, count=0.
2. Push 16 chars 8'h00..8'h0F with rx_trig=2'b10 -> rx_int rises when count=8; fifo_full=1 at 16. A 17th push (8'hFF) -> overrun_err=1, contents intact. Popping all 16 yields 00..0F in order; lsr_rd clears overrun_err.
3. FIFO full, push 8'h55 with rd_en in the same cycle -> head 00 popped, 55 stored at tail, count stays 16, overrun_err stays 0.
4. Push 8'h11 with rx_perr=1, then 8'h22 with rx_perr=0 -> fifo_perr=1 and rd_perr=1 at head. After one pop: rd_perr=0, fifo_perr=0.
5. One push, then no activity for TIMEOUT_CYC=64 cycles -> timeout_int asserts at cycle 64 after the push and deasserts the cycle after rd_en.
6. rx_ferr rising and lsr_rd in the same cycle -> framing_err=1. Later, with 3 entries held, assert reset low mid-stream -> all outputs 0 immediately. Also check separately: fifo_clr with a simultaneous push leaves count=0.
